stream_window_sched: RTL and testbench

Round-robin scheduler that shares one constant-bitstream ROM (1024-bit stochastic constant such as e^-k) between N requesters, e.g. sigmoid neuron units.
- Grants the stream to one requester at a time for a fixed evaluation window.
- Drives the ROM bit index and the stream-enable.
- Popcounts the granted requester's returned result bitstream over the window and reports the count with a done pulse.
- Sits between the constant-stream ROM and the neuron array in the sigmoid path.

---
 rtl/stream_window_sched.sv | 205 ++++++++++++++++++++
 tb/tb_stream_window_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_window_sched.sv
// ---------------------------------------------------------------------------
// stream_window_sched
//
// Round-robin scheduler that time-shares one constant-bitstream ROM between
// N_REQ requesters (for example sigmoid neuron units). The winner is granted
// the stream for a window of WINDOW cycles. During the window the block
// drives the ROM bit index and stream_en. It also popcounts the winner's
// returned result bitstream. When the window closes, the count is reported
// with a one-cycle done pulse. A requester that drops its request mid-window
// ends the window early with a one-cycle abort pulse.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   req        in   [N_REQ]  per-requester window request (level)
//   res_bit    in   [N_REQ]  per-requester result bit, sampled with idx
//   grant      out  [N_REQ]  registered one-hot grant, zero when idle
//   stream_en  out  high while a window runs
//   idx        out  [IDX_W]  ROM bit index, 0..WINDOW-1
//   done       out  one-cycle pulse, count/done_id valid
//   done_id    out  [$clog2(N_REQ)] requester whose window completed
//   count      out  [CNT_W]  ones seen on the granted res_bit over the window
//   abort      out  one-cycle pulse when a window is cut short
// ---------------------------------------------------------------------------
module stream_window_sched #(
   parameter int N_REQ  = 4,
   parameter int WINDOW = 1024,
   parameter int IDX_W  = 10,
   parameter int CNT_W  = 11
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           res_bit,
   output logic [N_REQ-1:0]           grant,
   output logic                       stream_en,
   output logic [IDX_W-1:0]           idx,
   output logic                       done,
   output logic [$clog2(N_REQ)-1:0]   done_id,
   output logic [CNT_W-1:0]           count,
   output logic                       abort
);

   localparam int SEL_W = $clog2(N_REQ);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Round-robin search starting at last+1, wrapping modulo N_REQ.
   // Returns {found, index}. Iterating from the farthest candidate down
   // lets the nearest set bit overwrite, so no early-exit flag is needed.
   function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [SEL_W-1:0] last);
      logic [SEL_W:0] pick;
      int             cand;
      pick = {(SEL_W + 1){1'b0}};
      for (int i = N_REQ; i >= 1; i--) begin
         cand = (int'(last) + i) % N_REQ;
         if (r[cand]) begin
            pick = {1'b1, SEL_W'(cand)};
         end
      end
      return pick;
   endfunction

   // One-hot encode a requester index.
   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
      logic [N_REQ-1:0] one;
      one = {{(N_REQ - 1){1'b0}}, 1'b1};
      return one << sel;
   endfunction

   state_t             state_q,     state_d;
   logic [SEL_W-1:0]   last_q,      last_d;
   logic [N_REQ-1:0]   grant_q,     grant_d;
   logic               stream_en_q, stream_en_d;
   logic [IDX_W-1:0]   idx_q,       idx_d;
   logic [CNT_W-1:0]   acc_q,       acc_d;
   logic [CNT_W-1:0]   count_q,     count_d;
   logic [SEL_W-1:0]   done_id_q,   done_id_d;
   logic               done_q,      done_d;
   logic               abort_q,     abort_d;

   logic [SEL_W:0]     pick_s;
   logic [CNT_W-1:0]   bit_ext_s;
   logic [CNT_W-1:0]   acc_next_s;

   // Next-state and next-output logic for the scheduler FSM.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      stream_en_d = stream_en_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      count_d     = count_q;
      done_id_d   = done_id_q;
      done_d      = 1'b0;
      abort_d     = 1'b0;

      pick_s = rr_pick(req, last_q);
      // last_q always holds the granted requester while a window runs.
      bit_ext_s  = {{(CNT_W - 1){1'b0}}, res_bit[last_q]};
      acc_next_s = acc_q + bit_ext_s;

      case (state_q)
         ST_IDLE: begin
            if (pick_s[SEL_W]) begin
               last_d      = pick_s[SEL_W-1:0];
               grant_d     = onehot(pick_s[SEL_W-1:0]);
               stream_en_d = 1'b1;
               idx_d       = {IDX_W{1'b0}};
               acc_d       = {CNT_W{1'b0}};
               state_d     = ST_RUN;
            end else begin
               grant_d     = {N_REQ{1'b0}};
               stream_en_d = 1'b0;
               idx_d       = {IDX_W{1'b0}};
            end
         end

         ST_RUN: begin
            // A dropped request wins over a simultaneous window end.
            if (!req[last_q]) begin
               abort_d     = 1'b1;
               grant_d     = {N_REQ{1'b0}};
               stream_en_d = 1'b0;
               idx_d       = {IDX_W{1'b0}};
               state_d     = ST_IDLE;
            end else if (idx_q == IDX_LAST) begin
               // The last cycle's bit is folded straight into count.
               acc_d       = acc_next_s;
               count_d     = acc_next_s;
               done_id_d   = last_q;
               done_d      = 1'b1;
               grant_d     = {N_REQ{1'b0}};
               stream_en_d = 1'b0;
               idx_d       = {IDX_W{1'b0}};
               state_d     = ST_DONE;
            end else begin
               acc_d       = acc_next_s;
               idx_d       = idx_q + IDX_ONE;
            end
         end

         ST_DONE: begin
            // done is high during this cycle. Always return to IDLE, so a
            // request still high there counts as a new one.
            grant_d     = {N_REQ{1'b0}};
            stream_en_d = 1'b0;
            idx_d       = {IDX_W{1'b0}};
            state_d     = ST_IDLE;
         end

         default: begin
            grant_d     = {N_REQ{1'b0}};
            stream_en_d = 1'b0;
            idx_d       = {IDX_W{1'b0}};
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset leaves requester 0 with first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_q      <= SEL_LAST;
         grant_q     <= {N_REQ{1'b0}};
         stream_en_q <= 1'b0;
         idx_q       <= {IDX_W{1'b0}};
         acc_q       <= {CNT_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         done_id_q   <= {SEL_W{1'b0}};
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         stream_en_q <= stream_en_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         done_id_q   <= done_id_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
      end
   end

   assign grant     = grant_q;
   assign stream_en = stream_en_q;
   assign idx       = idx_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign count     = count_q;
   assign abort     = abort_q;

endmodule

// File: tb/tb_stream_window_sched.sv
// ---------------------------------------------------------------------------
// tb_stream_window_sched
//
// Self-checking bench for stream_window_sched. It uses two instances: the
// default WINDOW=1024 block, and a WINDOW=8 block for the short-pattern case.
// Expected done/abort events are queued when stimulus is applied. They are
// popped and compared when the DUT pulses done or abort.
// ---------------------------------------------------------------------------
module tb_stream_window_sched;

   localparam int W    = 1024;
   localparam int W8   = 8;
   localparam int M_ONE  = 0;
   localparam int M_TOG  = 1;
   localparam int M_ZERO = 2;
   localparam int M_MOD  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, res_bit, grant;
   logic        stream_en, done, abort;
   logic [9:0]  idx;
   logic [1:0]  done_id;
   logic [10:0] count;

   logic [3:0]  req8, res8, grant8;
   logic        stream_en8, done8, abort8;
   logic [2:0]  idx8;
   logic [1:0]  done_id8;
   logic [3:0]  count8;

   int          mode;
   int          exp_lane;
   logic [3:0]  noise;
   logic [0:7]  pat8;
   int          re_cnt [4];
   int          n_pass, n_chk;

   typedef struct packed {
      logic        is_abort;
      logic [3:0]  id;
      logic [10:0] cnt;
   } ev_t;

   ev_t exp_q  [$];
   ev_t exp8_q [$];

   always #5 clk = ~clk;

   stream_window_sched dut (
      .clk(clk), .rst(rst), .req(req), .res_bit(res_bit), .grant(grant),
      .stream_en(stream_en), .idx(idx), .done(done), .done_id(done_id),
      .count(count), .abort(abort)
   );

   stream_window_sched #(.N_REQ(4), .WINDOW(W8), .IDX_W(3), .CNT_W(4)) dut8 (
      .clk(clk), .rst(rst), .req(req8), .res_bit(res8), .grant(grant8),
      .stream_en(stream_en8), .idx(idx8), .done(done8), .done_id(done_id8),
      .count(count8), .abort(abort8)
   );

   // Result bitstreams: the lane under test follows the mode, others are noise.
   always_comb begin
      res_bit = noise;
      for (int k = 0; k < 4; k++) begin
         if (mode == M_MOD) begin
            res_bit[k] = ((int'(idx) % (k + 2)) == 0);
         end else if (k == exp_lane) begin
            case (mode)
               M_ONE:   res_bit[k] = 1'b1;
               M_TOG:   res_bit[k] = ~idx[0];
               default: res_bit[k] = 1'b0;
            endcase
         end else begin
            res_bit[k] = noise[k];
         end
      end
   end

   // Short-window instance: requester 1 replays the 8-bit pattern.
   always_comb begin
      res8    = noise;
      res8[1] = pat8[idx8];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic ev_t mk_ev(input logic ab, input int id, input int cnt);
      ev_t e;
      e.is_abort = ab;
      e.id       = 4'(id);
      e.cnt      = 11'(cnt);
      return e;
   endfunction

   // Advance one cycle and sample at the falling edge: handle re-request
   // countdowns, check invariants, and score any done/abort event.
   task automatic tick();
      ev_t e;
      @(negedge clk);
      noise = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
         if (re_cnt[k] > 0) begin
            re_cnt[k]--;
            if (re_cnt[k] == 0) req[k] = 1'b1;
         end
      end
      chk("excl", 32'(done & abort), 32'd0);
      chk("onehot", 32'($countones(grant) > 1), 32'd0);
      chk("excl8", 32'(done8 & abort8), 32'd0);
      if (done || abort) begin
         if (exp_q.size() == 0) begin
            chk("unexp_event", 32'({done, abort}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ev_abort",   32'(abort),   32'(e.is_abort));
            chk("ev_done_id", 32'(done_id), 32'(e.id));
            chk("ev_count",   32'(count),   32'(e.cnt));
         end
      end
      if (done8 || abort8) begin
         if (exp8_q.size() == 0) begin
            chk("unexp_event8", 32'({done8, abort8}), 32'd0);
         end else begin
            e = exp8_q.pop_front();
            chk("ev8_abort",   32'(abort8),   32'(e.is_abort));
            chk("ev8_done_id", 32'(done_id8), 32'(e.id));
            chk("ev8_count",   32'(count8),   32'(e.cnt));
         end
      end
   endtask

   task automatic wait_sen(input string tag, output int waited);
      waited = 0;
      while (!stream_en && waited < 50) begin
         tick();
         waited++;
      end
      chk(tag, 32'(stream_en), 32'd1);
   endtask

   // Called on the first window cycle; returns on the DONE cycle.
   task automatic run_out(input string tag, input bit check_idx);
      int len;
      len = 0;
      while (stream_en && len < W + 8) begin
         if (check_idx) chk({tag, "_idx"}, 32'(idx), 32'(len));
         len++;
         tick();
      end
      chk({tag, "_len"}, 32'(len), 32'(W));
      chk({tag, "_done"}, 32'(done), 32'd1);
   endtask

   initial begin
      int          w;
      int          t;
      int          lanes [5];
      int          cnts  [4];
      logic [7:0]  pat_v;

      n_pass = 0; n_chk = 0;
      rst = 1'b1; req = 4'b0000; req8 = 4'b0000;
      mode = M_ONE; exp_lane = 0; noise = 4'b0000;
      pat_v = 8'b11010011; pat8 = pat_v;
      for (int k = 0; k < 4; k++) re_cnt[k] = 0;
      lanes = '{0, 1, 2, 3, 0};
      cnts  = '{512, 342, 256, 205};

      tick(); tick();
      chk("rst_grant",     32'(grant),     32'd0);
      chk("rst_stream_en", 32'(stream_en), 32'd0);
      chk("rst_idx",       32'(idx),       32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_done_id",   32'(done_id),   32'd0);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_abort",     32'(abort),     32'd0);
      rst = 1'b0;
      tick();

      // 1: constant ones on requester 0, one-cycle grant latency.
      exp_q.push_back(mk_ev(1'b0, 0, 1024));
      req[0] = 1'b1;
      tick();
      chk("t1_grant",     32'(grant),     32'd1);
      chk("t1_stream_en", 32'(stream_en), 32'd1);
      run_out("t1", 1'b1);
      req[0] = 1'b0;
      tick();

      // 2: alternating bits then all zeros.
      mode = M_TOG;
      exp_q.push_back(mk_ev(1'b0, 0, 512));
      req[0] = 1'b1;
      wait_sen("t2a_start", w);
      run_out("t2a", 1'b0);
      req[0] = 1'b0;
      tick();
      mode = M_ZERO;
      exp_q.push_back(mk_ev(1'b0, 0, 0));
      req[0] = 1'b1;
      wait_sen("t2b_start", w);
      run_out("t2b", 1'b0);
      req[0] = 1'b0;
      tick();

      // 3: fairness from a fresh pointer, lanes re-request 3 cycles after done.
      rst = 1'b1; tick(); rst = 1'b0; tick();
      mode = M_MOD;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk_ev(1'b0, lanes[i], cnts[lanes[i]]));
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_sen("t3_start", w);
         if (i > 0) chk("t3_gap_ge2", 32'(w >= 2), 32'd1);
         chk("t3_grant", 32'(grant), 32'(4'b0001 << lanes[i]));
         run_out("t3", 1'b0);
         req[lanes[i]] = 1'b0;
         re_cnt[lanes[i]] = 3;
      end
      for (int k = 0; k < 4; k++) re_cnt[k] = 0;
      req = 4'b0000;
      tick(); tick();

      // 4: requester 2 drops at idx 100; pending requester 3 follows.
      exp_q.push_back(mk_ev(1'b1, 0, 512));
      exp_q.push_back(mk_ev(1'b0, 3, 205));
      req = 4'b1100;
      wait_sen("t4_start", w);
      chk("t4_grant", 32'(grant), 32'd4);
      t = 0;
      while (idx != 10'd100 && t < 200) begin
         tick();
         t++;
      end
      chk("t4_at100", 32'(idx), 32'd100);
      req[2] = 1'b0;
      tick();
      chk("t4_abort",     32'(abort),     32'd1);
      chk("t4_ab_grant",  32'(grant),     32'd0);
      chk("t4_ab_sen",    32'(stream_en), 32'd0);
      chk("t4_ab_idx",    32'(idx),       32'd0);
      chk("t4_ab_done",   32'(done),      32'd0);
      tick();
      chk("t4_next_grant", 32'(grant), 32'd8);
      run_out("t4b", 1'b0);
      req[3] = 1'b0;
      tick();

      // 5: reset mid-window; afterwards requester 0 has first priority.
      req = 4'b0010;
      wait_sen("t5_start", w);
      chk("t5_grant", 32'(grant), 32'd2);
      t = 0;
      while (idx != 10'd500 && t < 600) begin
         tick();
         t++;
      end
      chk("t5_at500", 32'(idx), 32'd500);
      rst = 1'b1;
      #1;
      chk("t5_rst_grant", 32'(grant),     32'd0);
      chk("t5_rst_sen",   32'(stream_en), 32'd0);
      chk("t5_rst_idx",   32'(idx),       32'd0);
      chk("t5_rst_count", 32'(count),     32'd0);
      chk("t5_rst_id",    32'(done_id),   32'd0);
      chk("t5_rst_done",  32'(done),      32'd0);
      chk("t5_rst_abort", 32'(abort),     32'd0);
      req = 4'b1111;
      tick(); tick();
      exp_q.push_back(mk_ev(1'b0, 0, 512));
      rst = 1'b0;
      tick();
      chk("t5_first_grant", 32'(grant), 32'd1);
      run_out("t5b", 1'b0);
      req = 4'b0000;
      tick(); tick();

      // 6: short window, pattern 11010011 on requester 1.
      exp8_q.push_back(mk_ev(1'b0, 1, 5));
      req8[1] = 1'b1;
      t = 0;
      while (!stream_en8 && t < 20) begin
         tick();
         t++;
      end
      chk("t6_grant", 32'(grant8), 32'd2);
      t = 0;
      while (stream_en8 && t < W8 + 8) begin
         t++;
         tick();
      end
      chk("t6_len",  32'(t),     32'(W8));
      chk("t6_done", 32'(done8), 32'd1);
      req8 = 4'b0000;
      tick(); tick();

      chk("sb_empty", 32'(exp_q.size() + exp8_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
